// File: rtl/fact_scheduler_if.sv
// Job, result and accelerator-bus signals of the factorial job scheduler.
// The slave modport is the scheduler's view. The master modport is the
// requester/accelerator side.
interface fact_scheduler_if;
  logic        job_valid;
  logic [3:0]  job_n;
  logic        job_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_ready;
  logic [1:0]  fa_a;
  logic        fa_we;
  logic [3:0]  fa_wd;
  logic [31:0] fa_rd;

  modport slave (
    input  job_valid, job_n, res_ready, fa_rd,
    output job_ready, res_valid, res_data, res_err, fa_a, fa_we, fa_wd
  );

  modport master (
    output job_valid, job_n, res_ready, fa_rd,
    input  job_ready, res_valid, res_data, res_err, fa_a, fa_we, fa_wd
  );
endinterface

// File: rtl/fact_scheduler.sv
// Factorial job scheduler. It queues n operands, runs one job at a time on the
// accelerator (load n, pulse go, poll status, read result), and queues {err, result}.
//
// state  | meaning
// IDLE   | waiting for a queued job and space in the result FIFO
// LOAD   | write n to the accelerator and pop the job FIFO
// GO     | write go = 1
// GO_CLR | write go = 0
// POLL   | read status until done/err or the poll budget runs out
// READ   | read the result and push it to the result FIFO
module fact_scheduler #(
  parameter int JDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  fact_scheduler_if.slave         bus,
  output logic                    busy,
  output logic [$clog2(JDEPTH):0] jobs_pending
);

  localparam int JAW = $clog2(JDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [JAW:0]  JFULL   = (JAW + 1)'(JDEPTH);
  localparam logic [RAW:0]  RFULL   = (RAW + 1)'(RDEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, GO, GO_CLR, POLL, READ} state_t;

  logic [3:0]     jmem [JDEPTH];
  logic [JAW-1:0] jwp, jrp;
  logic [JAW:0]   jcnt;
  logic [32:0]    rmem [RDEPTH];
  logic [RAW-1:0] rwp, rrp;
  logic [RAW:0]   rcnt;
  logic           ready_en;

  state_t         state;
  logic [CW-1:0]  poll_cnt;
  logic           err_q;
  logic [1:0]     fa_a_q;
  logic           fa_we_q;
  logic [3:0]     fa_wd_q;

  logic           j_push, j_pop, r_push, r_pop, timeout_hit;
  logic [32:0]    r_wdata;

  // ready_en keeps job_ready low until the first cycle after reset is released
  assign bus.job_ready = ready_en && (jcnt != JFULL);
  assign j_push        = bus.job_valid && bus.job_ready;
  assign j_pop         = (state == LOAD);
  assign timeout_hit   = (state == POLL) && !bus.fa_rd[1] && !bus.fa_rd[0] &&
                         (poll_cnt == TO_LAST);
  assign r_push        = (state == READ) || timeout_hit;
  assign r_wdata       = (state == READ && !err_q) ? {1'b0, bus.fa_rd} : {1'b1, 32'd0};
  assign bus.res_valid = (rcnt != '0);
  assign bus.res_data  = bus.res_valid ? rmem[rrp][31:0] : 32'd0;
  assign bus.res_err   = bus.res_valid && rmem[rrp][32];
  assign r_pop         = bus.res_valid && bus.res_ready;
  assign bus.fa_a      = fa_a_q;
  assign bus.fa_we     = fa_we_q;
  assign bus.fa_wd     = fa_wd_q;
  assign jobs_pending  = jcnt;

  // Job FIFO: pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      jwp      <= '0;
      jrp      <= '0;
      jcnt     <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (j_push) begin
        jmem[jwp] <= bus.job_n;
        jwp       <= jwp + 1'b1;
      end
      if (j_pop) jrp <= jrp + 1'b1;
      case ({j_push, j_pop})
        2'b10:   jcnt <= jcnt + 1'b1;
        2'b01:   jcnt <= jcnt - 1'b1;
        default: jcnt <= jcnt;
      endcase
    end
  end

  // Result FIFO: space was reserved in IDLE, so a push never finds it full
  always_ff @(posedge clock) begin
    if (reset) begin
      rwp  <= '0;
      rrp  <= '0;
      rcnt <= '0;
    end else begin
      if (r_push) begin
        rmem[rwp] <= r_wdata;
        rwp       <= rwp + 1'b1;
      end
      if (r_pop) rrp <= rrp + 1'b1;
      case ({r_push, r_pop})
        2'b10:   rcnt <= rcnt + 1'b1;
        2'b01:   rcnt <= rcnt - 1'b1;
        default: rcnt <= rcnt;
      endcase
    end
  end

  // Sequencer. Bus outputs are registered, so they are set for the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      poll_cnt <= '0;
      err_q    <= 1'b0;
      fa_a_q   <= 2'd2;
      fa_we_q  <= 1'b0;
      fa_wd_q  <= 4'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (jcnt != '0 && rcnt != RFULL) begin
            state   <= LOAD;
            fa_a_q  <= 2'd0;
            fa_we_q <= 1'b1;
            fa_wd_q <= jmem[jrp];
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          state    <= GO;
          poll_cnt <= '0;
          fa_a_q   <= 2'd1;
          fa_wd_q  <= 4'b0001;
        end
        GO: begin
          state   <= GO_CLR;
          fa_wd_q <= 4'd0;
        end
        GO_CLR: begin
          state   <= POLL;
          fa_a_q  <= 2'd2;
          fa_we_q <= 1'b0;
        end
        POLL: begin
          if (bus.fa_rd[1] || bus.fa_rd[0]) begin
            err_q  <= bus.fa_rd[1];
            state  <= READ;
            fa_a_q <= 2'd3;
          end else if (poll_cnt == TO_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        READ: begin
          state  <= IDLE;
          fa_a_q <= 2'd2;
          busy   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          fa_a_q  <= 2'd2;
          fa_we_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
